// File: rtl/word_lane_serializer_pkg.sv
// Shared types and helpers for the word-to-lane serializer.
// State encoding plus the width helper used for lane index ports.
package word_lane_serializer_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Index width never collapses to zero, even for a one-lane word.
    function automatic int idx_w(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/word_lane_serializer_lane_mux.sv
// N-way lane selector: picks LANE_W bits of a word by lane index.
// Purely combinational; lane 0 is the least significant lane.
module lane_mux #(
    parameter int WORD_W = 32,
    parameter int LANE_W = 8,
    parameter int IW     = 2
) (
    input  logic [WORD_W-1:0] word,
    input  logic [IW-1:0]     idx,
    output logic [LANE_W-1:0] lane
);

    localparam int N = WORD_W / LANE_W;

    always_comb begin
        lane = '0;
        for (int i = 0; i < N; i++) begin
            if (idx == IW'(i)) lane = word[i*LANE_W +: LANE_W];
        end
    end

endmodule

// File: rtl/word_lane_serializer.sv
// Splits one WORD_W word per handshake into LANE_W lanes,
// with selectable lane order and partial-word counts.
module word_lane_serializer
    import word_lane_serializer_pkg::*;
#(
    parameter int WORD_W    = 32,
    parameter int LANE_W    = 8,
    parameter bit MSB_FIRST = 1'b1,
    localparam int N        = WORD_W / LANE_W,
    localparam int IW       = idx_w(N)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_word,
    input  logic [IW:0]       in_count,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LANE_W-1:0] out_lane,
    output logic [IW-1:0]     out_idx,
    output logic              out_last
);

    localparam logic [IW:0] N_C = (IW+1)'(N);

    state_t            state;
    logic [WORD_W-1:0] word_q;
    logic [IW:0]       cnt_q;
    logic [IW-1:0]     cnt;
    logic [IW-1:0]     idx;
    logic [IW:0]       eff_cnt;
    logic [LANE_W-1:0] lane_sel;
    logic              send;
    logic              last;
    logic              in_fire;
    logic              out_fire;

    assign send     = (state == S_SEND);
    assign eff_cnt  = (in_count == '0 || in_count > N_C) ? N_C : in_count;
    assign idx      = MSB_FIRST ? (IW'(N-1) - cnt) : cnt;
    assign last     = send && ({1'b0, cnt} == cnt_q - (IW+1)'(1));
    assign out_fire = send && out_ready;
    // Ready opens in the last-lane cycle so the next word follows gap-free.
    assign in_ready = !reset && (!send || (out_fire && last));
    assign in_fire  = in_valid && in_ready;

    lane_mux #(
        .WORD_W (WORD_W),
        .LANE_W (LANE_W),
        .IW     (IW)
    ) u_lane_mux (
        .word (word_q),
        .idx  (idx),
        .lane (lane_sel)
    );

    assign out_valid = send;
    assign out_lane  = send ? lane_sel : '0;
    assign out_idx   = send ? idx : '0;
    assign out_last  = last;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            cnt_q  <= '0;
            word_q <= '0;
        end else if (in_fire) begin
            state  <= S_SEND;
            word_q <= in_word;
            cnt_q  <= eff_cnt;
            cnt    <= '0;
        end else if (out_fire) begin
            if (last) begin
                state <= S_IDLE;
                cnt   <= '0;
            end else begin
                cnt <= cnt + IW'(1);
            end
        end
    end

endmodule

// File: tb/tb_word_lane_serializer.sv
// Randomized and directed bench for word_lane_serializer.
// Three instances: 32/8 MSB-first, 32/8 LSB-first, 64/16 MSB-first.
module tb_word_lane_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [2:0]  in_valid;
    logic [2:0]  out_ready;
    wire  [2:0]  in_ready;
    wire  [2:0]  out_valid;
    wire  [2:0]  out_last;
    logic [31:0] w0, w1;
    logic [63:0] w2;
    logic [2:0]  c0, c1, c2;
    wire  [7:0]  l0, l1;
    wire  [15:0] l2;
    wire  [1:0]  x0, x1, x2;

    logic [63:0] a_word [3];
    logic [15:0] a_lane [3];
    logic [1:0]  a_idx  [3];
    logic [2:0]  a_cnt  [3];

    assign a_word[0] = {32'h0, w0};
    assign a_word[1] = {32'h0, w1};
    assign a_word[2] = w2;
    assign a_lane[0] = {8'h0, l0};
    assign a_lane[1] = {8'h0, l1};
    assign a_lane[2] = l2;
    assign a_idx[0]  = x0;
    assign a_idx[1]  = x1;
    assign a_idx[2]  = x2;
    assign a_cnt[0]  = c0;
    assign a_cnt[1]  = c1;
    assign a_cnt[2]  = c2;

    word_lane_serializer #(
        .WORD_W(32), .LANE_W(8), .MSB_FIRST(1'b1)
    ) u_msb (
        .clk(clk), .reset(reset),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_word(w0), .in_count(c0),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_lane(l0), .out_idx(x0), .out_last(out_last[0])
    );

    word_lane_serializer #(
        .WORD_W(32), .LANE_W(8), .MSB_FIRST(1'b0)
    ) u_lsb (
        .clk(clk), .reset(reset),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_word(w1), .in_count(c1),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_lane(l1), .out_idx(x1), .out_last(out_last[1])
    );

    word_lane_serializer #(
        .WORD_W(64), .LANE_W(16), .MSB_FIRST(1'b1)
    ) u_w64 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_word(w2), .in_count(c2),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_lane(l2), .out_idx(x2), .out_last(out_last[2])
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input int i,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d] @%0t got %h want %h",
                     nm, i, $time, act, exp);
        end
    endtask

    // Reference model: current word, lanes to send, lanes sent.
    logic [63:0] m_word [3];
    int          m_k    [3];
    int          m_j    [3];
    int          cyc = 0;

    function automatic int lw(input int i);
        return (i == 2) ? 16 : 8;
    endfunction

    function automatic bit msbf(input int i);
        return (i != 1);
    endfunction

    function automatic int eff(input logic [2:0] c);
        return (c == 0 || c > 4) ? 4 : int'(c);
    endfunction

    function automatic bit busy_f(input int i);
        return m_j[i] < m_k[i];
    endfunction

    function automatic bit ready_f(input int i);
        bool_last_chk: begin end
        return !reset && (!busy_f(i) ||
               (m_j[i] == m_k[i] - 1 && out_ready[i]));
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                m_k[i]    <= 0;
                m_j[i]    <= 0;
                m_word[i] <= '0;
            end else if (in_valid[i] && ready_f(i)) begin
                m_word[i] <= a_word[i];
                m_k[i]    <= eff(a_cnt[i]);
                m_j[i]    <= 0;
            end else if (busy_f(i) && out_ready[i]) begin
                m_j[i] <= m_j[i] + 1;
            end
        end
    end

    always @(negedge clk) begin : cmp
        int          x;
        logic [63:0] mask;
        if (cyc > 0) begin
            for (int i = 0; i < 3; i++) begin
                chk("in_ready", i, 64'(in_ready[i]), 64'(ready_f(i)));
                chk("out_valid", i, 64'(out_valid[i]), 64'(busy_f(i)));
                if (busy_f(i)) begin
                    x = msbf(i) ? 3 - m_j[i] : m_j[i];
                    mask = (64'd1 << lw(i)) - 64'd1;
                    chk("out_lane", i, 64'(a_lane[i]),
                        (m_word[i] >> (x * lw(i))) & mask);
                    chk("out_idx", i, 64'(a_idx[i]), 64'(x));
                    chk("out_last", i, 64'(out_last[i]),
                        64'(m_j[i] == m_k[i] - 1));
                end
            end
        end
    end

    logic [63:0] lanes_cat;
    logic [15:0] idx_cat;
    logic [7:0]  last_cat;
    logic [7:0]  valid_cat;
    logic [7:0]  ready_cat;

    task automatic clr();
        lanes_cat = '0;
        idx_cat   = '0;
        last_cat  = '0;
        valid_cat = '0;
        ready_cat = '0;
    endtask

    task automatic rec(input int i);
        @(negedge clk);
        lanes_cat = (lanes_cat << lw(i)) | 64'(a_lane[i]);
        idx_cat   = (idx_cat << 2) | 16'(a_idx[i]);
        last_cat  = (last_cat << 1) | 8'(out_last[i]);
        valid_cat = (valid_cat << 1) | 8'(out_valid[i]);
        ready_cat = (ready_cat << 1) | 8'(in_ready[i]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = '0;
        out_ready = 3'b111;
        w0 = '0; w1 = '0; w2 = '0;
        c0 = '0; c1 = '0; c2 = '0;
        tick();
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_valid", 0, 64'(out_valid), 64'h0);
        chk("rst_ready", 0, 64'(in_ready), 64'h7);
        chk("rst_lane", 0, 64'(l0), 64'h0);

        // Full word, MSB first.
        tick();
        in_valid[0] = 1'b1; w0 = 32'h12345678; c0 = 3'd0;
        tick();
        in_valid[0] = 1'b0;
        clr();
        repeat (4) rec(0);
        chk("t1_lanes", 0, lanes_cat, 64'h12345678);
        chk("t1_idx", 0, 64'(idx_cat), 64'b11_10_01_00);
        chk("t1_last", 0, 64'(last_cat), 64'b0001);
        chk("t1_valid", 0, 64'(valid_cat), 64'hF);
        @(negedge clk);
        chk("t1_idle", 0, 64'({out_valid[0], in_ready[0]}), 64'b01);

        // Partial word, LSB first.
        tick();
        in_valid[1] = 1'b1; w1 = 32'h12345678; c1 = 3'd3;
        tick();
        in_valid[1] = 1'b0;
        clr();
        repeat (3) rec(1);
        chk("t2_lanes", 1, lanes_cat, 64'h785634);
        chk("t2_idx", 1, 64'(idx_cat), 64'b00_01_10);
        chk("t2_last", 1, 64'(last_cat), 64'b001);
        @(negedge clk);
        chk("t2_done", 1, 64'(out_valid[1]), 64'h0);

        // Backpressure while lane 56 is shown.
        tick();
        in_valid[1] = 1'b1; w1 = 32'h12345678; c1 = 3'd0;
        tick();
        in_valid[1] = 1'b0;
        clr();
        rec(1);
        for (int s = 0; s < 6; s++) begin
            tick();
            out_ready[1] = (s >= 3);
            rec(1);
        end
        chk("t3_lanes", 1, lanes_cat, 64'h78565656563412);
        chk("t3_idx", 1, 64'(idx_cat), 64'b00_01_01_01_01_10_11);
        chk("t3_ready", 1, 64'(ready_cat), 64'b0000001);
        chk("t3_last", 1, 64'(last_cat), 64'b0000001);

        // Back-to-back words with no bubble.
        tick();
        in_valid[0] = 1'b1; w0 = 32'hA5A5A5A5; c0 = 3'd0;
        tick();
        w0 = 32'h0F0E0D0C;
        clr();
        for (int j = 0; j < 8; j++) begin
            rec(0);
            if (j == 3) begin
                tick();
                in_valid[0] = 1'b0;
            end
        end
        chk("t4_lanes", 0, lanes_cat, 64'hA5A5A5A50F0E0D0C);
        chk("t4_valid", 0, 64'(valid_cat), 64'hFF);
        chk("t4_ready", 0, 64'(ready_cat), 64'b0001_0001);
        chk("t4_idx", 0, 64'(idx_cat), 64'hE4E4);

        // Reset during the second lane.
        tick();
        in_valid[0] = 1'b1; w0 = 32'h12345678; c0 = 3'd0;
        tick();
        in_valid[0] = 1'b0;
        tick();
        reset = 1'b1;
        @(negedge clk);
        chk("t5_lane2", 0, 64'(l0), 64'h34);
        chk("t5_rst_rdy", 0, 64'(in_ready), 64'h0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("t5_out", 0,
            64'({out_valid[0], l0, x0, out_last[0], in_ready[0]}),
            64'b0_00000000_00_0_1);
        tick();
        in_valid[0] = 1'b1; w0 = 32'hDEADBEEF; c0 = 3'd0;
        tick();
        in_valid[0] = 1'b0;
        clr();
        repeat (4) rec(0);
        chk("t5_lanes", 0, lanes_cat, 64'hDEADBEEF);
        chk("t5_idx", 0, 64'(idx_cat), 64'b11_10_01_00);

        // Count above N acts as N.
        tick();
        in_valid[0] = 1'b1; w0 = 32'hCAFEF00D; c0 = 3'd7;
        tick();
        in_valid[0] = 1'b0;
        clr();
        repeat (4) rec(0);
        chk("t6_lanes", 0, lanes_cat, 64'hCAFEF00D);
        chk("t6_last", 0, 64'(last_cat), 64'b0001);
        rec(0);
        chk("t6_valid", 0, 64'(valid_cat), 64'b11110);

        // Wide instance: 64-bit word, 16-bit lanes.
        tick();
        in_valid[2] = 1'b1; w2 = 64'h0011223344556677; c2 = 3'd0;
        tick();
        in_valid[2] = 1'b0;
        clr();
        repeat (4) rec(2);
        chk("t7_lanes", 2, lanes_cat, 64'h0011223344556677);
        chk("t7_idx", 2, 64'(idx_cat), 64'b11_10_01_00);

        // Random traffic on all three instances.
        for (int n = 0; n < 1500; n++) begin
            tick();
            reset     = ($urandom_range(0, 199) == 0);
            in_valid  = 3'($urandom_range(0, 7));
            out_ready[0] = ($urandom_range(0, 3) != 0);
            out_ready[1] = ($urandom_range(0, 3) != 0);
            out_ready[2] = ($urandom_range(0, 1) != 0);
            w0 = $urandom;
            w1 = $urandom;
            w2 = {$urandom, $urandom};
            c0 = 3'($urandom_range(0, 7));
            c1 = 3'($urandom_range(0, 7));
            c2 = 3'($urandom_range(0, 7));
        end
        tick();
        reset     = 1'b0;
        in_valid  = '0;
        out_ready = 3'b111;
        repeat (8) tick();
        @(negedge clk);
        chk("drain", 0, 64'(out_valid), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/word_lane_serializer.md
Name: word_lane_serializer

Overview:
- Parametrised successor to the datapath word splitter.
- Accepts one WORD_W-bit word per valid/ready handshake and emits it as a sequence of LANE_W-bit lanes, one lane per output handshake.
- Supports a configurable lane order and partial words of 1..N lanes.
- Sits between the CPU-side word bus and byte-wide peripherals (UART/display/byte store path).

Parameters:
- WORD_W, 32, input word width; must be an integer multiple of LANE_W.
- LANE_W, 8, output lane width.
- MSB_FIRST, 1, 1 = emit the most significant lane first (word[WORD_W-1 -: LANE_W]); 0 = emit the least significant lane first.
- Derived constants (localparam, not overridable):
  - N = WORD_W/LANE_W.
  - IW = clog2(N), minimum 1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  block can accept a word this cycle.
- in_word  input  WORD_W  word to split.
- in_count  input  IW+1  number of lanes to emit; 0 or >N means N.
- out_valid  output  1  out_lane holds a valid lane.
- out_ready  input  1  downstream accepts the lane.
- out_lane  output  LANE_W  current lane.
- out_idx  output  IW  position of the current lane in the original word (0 = least significant lane).
- out_last  output  1  current lane is the final lane of this word.

Behaviour:
- Transfers:
  - Input transfer = in_valid && in_ready at a rising edge.
  - Output transfer = out_valid && out_ready at a rising edge.
- State machine, two states:
  - IDLE: out_valid=0, in_ready=1.
  - SEND: out_valid=1.
- Transitions:
  - IDLE -> SEND on an input transfer. Capture in_word into word_q and the effective count into cnt_q. Set the lane counter to 0.
  - SEND stays in SEND on an output transfer with out_last=0. The lane counter increments.
  - SEND -> IDLE on an output transfer with out_last=1 and no input transfer in the same cycle.
  - SEND -> SEND (back-to-back) on an output transfer with out_last=1 and in_valid=1. The new word is captured and the counter restarts at 0 in the same edge, so there are no bubble cycles between words.
- in_ready = (state==IDLE) || (out_valid && out_ready && out_last). This is combinational from out_ready. in_valid must not depend combinationally on in_ready.
- Latency:
  - The first lane of a word is presented in the cycle after its input transfer.
  - A word of k lanes occupies exactly k cycles when out_ready is held at 1.
- Lane selection:
  - MSB_FIRST=1: out_idx = N-1-cnt.
  - MSB_FIRST=0: out_idx = cnt.
  - out_lane = word_q[out_idx*LANE_W +: LANE_W].
  - out_last = (cnt == cnt_q-1).
- Partial words:
  - Only the first cnt_q lanes in emission order are sent.
  - With MSB_FIRST=1 and count 2, lanes 3 and 2 are emitted (the upper half).
- Backpressure: while out_valid=1 and out_ready=0, out_lane, out_idx and out_last hold stable and the counter does not advance.
- in_word and in_count are sampled only on an input transfer. Changes at other times have no effect.
- Reset:
  - Reset values: state IDLE, cnt=0, cnt_q=0, word_q=0, out_valid=0, out_lane=0, out_idx=0, out_last=0, in_ready=1 after reset deasserts.
  - While reset=1, in_ready=0.
  - Reset asserted mid-word abandons the remaining lanes. No lane is emitted in the cycle after the reset edge.
- Reset has priority over all simultaneous handshake events.

Decomposition:
- Shared package (or include file) holds:
  - the clog2 function;
  - state encodings S_IDLE=1'b0, S_SEND=1'b1.
- One natural sub-module, lane_mux: a combinational N-way LANE_W selector from word_q and out_idx. It generalises the fixed byte-extraction assigns and is reusable by other blocks.
- All state, counters and handshakes live in the top-level word_lane_serializer.

Test Plan:
- Defaults, MSB_FIRST=1, in_word=32'h12345678, in_count=0, out_ready=1 -> lanes 12,34,56,78 on four consecutive cycles; out_idx 3,2,1,0; out_last=1 on the 78 lane only; in_ready returns to 1.
- MSB_FIRST=0, same word, in_count=3 -> lanes 78,56,34 with out_idx 0,1,2; out_last on 34; the 12 lane is never emitted.
- Backpressure: out_ready=0 for 3 cycles after the 56 lane appears -> 56 and out_idx=1 held stable for those 3 cycles; no input transfer; the sequence then resumes with 34,12.
- Back-to-back: words A5A5A5A5 then 0F0E0D0C, in_valid held at 1, out_ready=1 -> 8 lanes in 8 consecutive cycles with no gap; in_ready=1 exactly in the cycle of A5's last lane.
- Reset mid-word: reset pulsed while the second lane of 12345678 is shown -> out_valid=0 and out_lane=0 the next cycle; the following word DEADBEEF emits DE,AD,BE,EF from lane 0.
- in_count=7 (> N) -> treated as 4; exactly four lanes are emitted. Parameter sweep WORD_W=64, LANE_W=16 with in_word=64'h0011223344556677 -> 0011,2233,4455,6677.
